// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode-side request fields, EX/MEM write info, EX-latched outputs.
interface id_ex_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned RW   = 3,
  parameter int unsigned CTLW = 8,
  parameter int unsigned CNTW = 16
);
  logic            id_valid;
  logic [RW-1:0]   id_rs_sel;
  logic            id_rs_used;
  logic [RW-1:0]   id_rt_sel;
  logic            id_rt_used;
  logic [DW-1:0]   id_rdata1;
  logic [DW-1:0]   id_rdata2;
  logic [DW-1:0]   id_imm;
  logic [RW-1:0]   id_dst_sel;
  logic            id_dst_we;
  logic            id_is_load;
  logic [CTLW-1:0] id_ctl;
  logic [RW-1:0]   mem_dst_sel;
  logic            mem_dst_we;
  logic            ex_stall;
  logic            flush;

  logic            id_stall;
  logic            ex_valid;
  logic [DW-1:0]   ex_a;
  logic [DW-1:0]   ex_b;
  logic [DW-1:0]   ex_imm;
  logic [RW-1:0]   ex_dst_sel;
  logic            ex_dst_we;
  logic            ex_is_load;
  logic [CTLW-1:0] ex_ctl;
  logic [CNTW-1:0] bubble_cnt;

  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used, id_rdata1, id_rdata2,
           id_imm, id_dst_sel, id_dst_we, id_is_load, id_ctl, mem_dst_sel, mem_dst_we,
           ex_stall, flush,
    input  id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_dst_sel, ex_dst_we, ex_is_load,
           ex_ctl, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used, id_rdata1, id_rdata2,
           id_imm, id_dst_sel, id_dst_we, id_is_load, id_ctl, mem_dst_sel, mem_dst_we,
           ex_stall, flush,
    output id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_dst_sel, ex_dst_we, ex_is_load,
           ex_ctl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with RAW hazard stall against EX and MEM pending writes.
// No forwarding path exists; WB writes are covered by the register-file bypass.
module id_ex_stage #(
  parameter int unsigned DW   = 16,
  parameter int unsigned RW   = 3,
  parameter int unsigned CTLW = 8,
  parameter int unsigned CNTW = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);
  localparam logic [0:0]      ST_EMPTY = 1'b0;
  localparam logic [0:0]      ST_FULL  = 1'b1;
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  logic [0:0]      state_q, state_d;
  logic            ex_dst_we_q, ex_dst_we_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [RW-1:0]   ex_dst_sel_q, ex_dst_sel_d;
  logic [DW-1:0]   ex_a_q, ex_a_d;
  logic [DW-1:0]   ex_b_q, ex_b_d;
  logic [DW-1:0]   ex_imm_q, ex_imm_d;
  logic [CTLW-1:0] ex_ctl_q, ex_ctl_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic ex_full;
  logic rs_match, rt_match, hz;

  assign ex_full = (state_q == ST_FULL);

  // Source operand collides with a write still in flight in EX or MEM
  always_comb begin
    rs_match = (ex_full & ex_dst_we_q & (ex_dst_sel_q == bus.id_rs_sel)) |
               (bus.mem_dst_we & (bus.mem_dst_sel == bus.id_rs_sel));
    rt_match = (ex_full & ex_dst_we_q & (ex_dst_sel_q == bus.id_rt_sel)) |
               (bus.mem_dst_we & (bus.mem_dst_sel == bus.id_rt_sel));
    hz       = bus.id_valid & ((bus.id_rs_used & rs_match) | (bus.id_rt_used & rt_match));
  end

  assign bus.id_stall = ~rst & ~bus.flush & (hz | bus.ex_stall);

  // Next-state: flush > ex_stall > hazard bubble > load
  always_comb begin
    state_d      = state_q;
    ex_dst_we_d  = ex_dst_we_q;
    ex_is_load_d = ex_is_load_q;
    ex_dst_sel_d = ex_dst_sel_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_imm_d     = ex_imm_q;
    ex_ctl_d     = ex_ctl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush) begin
      state_d      = ST_EMPTY;
      ex_dst_we_d  = 1'b0;
      ex_is_load_d = 1'b0;
      ex_dst_sel_d = '0;
      ex_a_d       = '0;
      ex_b_d       = '0;
      ex_imm_d     = '0;
      ex_ctl_d     = '0;
    end else if (bus.ex_stall) begin
      state_d = state_q;
    end else if (hz) begin
      state_d      = ST_EMPTY;
      ex_dst_we_d  = 1'b0;
      ex_is_load_d = 1'b0;
      bubble_cnt_d = (bubble_cnt_q == CNT_MAX) ? bubble_cnt_q : bubble_cnt_q + CNTW'(1);
    end else begin
      state_d      = bus.id_valid ? ST_FULL : ST_EMPTY;
      ex_dst_we_d  = bus.id_dst_we & bus.id_valid;
      ex_is_load_d = bus.id_is_load & bus.id_valid;
      ex_dst_sel_d = bus.id_dst_sel;
      ex_a_d       = bus.id_rdata1;
      ex_b_d       = bus.id_rdata2;
      ex_imm_d     = bus.id_imm;
      ex_ctl_d     = bus.id_ctl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      ex_dst_we_q  <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_dst_sel_q <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      ex_ctl_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ex_dst_we_q  <= ex_dst_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_dst_sel_q <= ex_dst_sel_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctl_q     <= ex_ctl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_full;
  assign bus.ex_dst_we  = ex_dst_we_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.ex_dst_sel = ex_dst_sel_q;
  assign bus.ex_a       = ex_a_q;
  assign bus.ex_b       = ex_b_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_ctl     = ex_ctl_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// against a pending-write-set model; a second instance with a 2-bit counter checks saturation.
module tb_id_ex_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_if #(.CNTW(16)) bus ();
  id_ex_if #(.CNTW(2))  bus2 ();

  id_ex_stage #(.CNTW(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage #(.CNTW(2))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_rs_sel   = bus.id_rs_sel;
  assign bus2.id_rs_used  = bus.id_rs_used;
  assign bus2.id_rt_sel   = bus.id_rt_sel;
  assign bus2.id_rt_used  = bus.id_rt_used;
  assign bus2.id_rdata1   = bus.id_rdata1;
  assign bus2.id_rdata2   = bus.id_rdata2;
  assign bus2.id_imm      = bus.id_imm;
  assign bus2.id_dst_sel  = bus.id_dst_sel;
  assign bus2.id_dst_we   = bus.id_dst_we;
  assign bus2.id_is_load  = bus.id_is_load;
  assign bus2.id_ctl      = bus.id_ctl;
  assign bus2.mem_dst_sel = bus.mem_dst_sel;
  assign bus2.mem_dst_we  = bus.mem_dst_we;
  assign bus2.ex_stall    = bus.ex_stall;
  assign bus2.flush       = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what EX holds, whether its data fields are defined, bubbles so far
  bit          m_init;
  bit          m_valid, m_we, m_ld, m_known;
  logic [2:0]  m_dst;
  logic [15:0] m_a, m_b, m_imm;
  logic [7:0]  m_ctl;
  int          m_bub;

  function automatic bit m_hazard();
    bit pending [8];
    for (int r = 0; r < 8; r++) pending[r] = 1'b0;
    if (m_valid && m_we) pending[m_dst] = 1'b1;
    if (bus.mem_dst_we) pending[bus.mem_dst_sel] = 1'b1;
    return bus.id_valid && ((bus.id_rs_used && pending[bus.id_rs_sel]) ||
                            (bus.id_rt_used && pending[bus.id_rt_sel]));
  endfunction

  function automatic bit m_stall();
    return !rst && !bus.flush && (m_hazard() || bus.ex_stall);
  endfunction

  task automatic model_update();
    if (rst) begin
      m_init = 1; m_valid = 0; m_we = 0; m_ld = 0; m_known = 1; m_bub = 0;
      m_dst = '0; m_a = '0; m_b = '0; m_imm = '0; m_ctl = '0;
    end else if (bus.flush) begin
      m_valid = 0; m_we = 0; m_ld = 0; m_known = 1;
      m_dst = '0; m_a = '0; m_b = '0; m_imm = '0; m_ctl = '0;
    end else if (bus.ex_stall) begin
      m_valid = m_valid;
    end else if (m_hazard()) begin
      m_valid = 0; m_we = 0; m_ld = 0; m_known = 0; m_bub++;
    end else begin
      m_valid = bus.id_valid;
      m_we    = bus.id_valid && bus.id_dst_we;
      m_ld    = bus.id_valid && bus.id_is_load;
      m_known = 1;
      m_dst = bus.id_dst_sel; m_a = bus.id_rdata1; m_b = bus.id_rdata2;
      m_imm = bus.id_imm; m_ctl = bus.id_ctl;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    if (m_init) begin
      chk("id_stall",   32'(bus.id_stall),   32'(m_stall()));
      chk("id_stall2",  32'(bus2.id_stall),  32'(m_stall()));
      chk("ex_valid",   32'(bus.ex_valid),   32'(m_valid));
      chk("ex_valid2",  32'(bus2.ex_valid),  32'(m_valid));
      chk("ex_dst_we",  32'(bus.ex_dst_we),  32'(m_we));
      chk("ex_is_load", 32'(bus.ex_is_load), 32'(m_ld));
      chk("bubble_cnt",  32'(bus.bubble_cnt),  32'((m_bub > 65535) ? 65535 : m_bub));
      chk("bubble_cnt2", 32'(bus2.bubble_cnt), 32'((m_bub > 3) ? 3 : m_bub));
      if (m_known) begin
        chk("ex_dst_sel", 32'(bus.ex_dst_sel), 32'(m_dst));
        chk("ex_a",       32'(bus.ex_a),       32'(m_a));
        chk("ex_b",       32'(bus.ex_b),       32'(m_b));
        chk("ex_imm",     32'(bus.ex_imm),     32'(m_imm));
        chk("ex_ctl",     32'(bus.ex_ctl),     32'(m_ctl));
      end
    end
  endtask

  // Inputs are set after a negedge; compare, clock, advance model, return at next negedge
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_rs_sel = '0; bus.id_rs_used = 0; bus.id_rt_sel = '0;
    bus.id_rt_used = 0; bus.id_rdata1 = '0; bus.id_rdata2 = '0; bus.id_imm = '0;
    bus.id_dst_sel = '0; bus.id_dst_we = 0; bus.id_is_load = 0; bus.id_ctl = '0;
    bus.mem_dst_sel = '0; bus.mem_dst_we = 0; bus.ex_stall = 0; bus.flush = 0;
  endtask

  task automatic set_instr(input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                           input logic rtu, input logic [15:0] d1, input logic [15:0] imm,
                           input logic [2:0] dst, input logic [7:0] ctl);
    bus.id_valid = 1; bus.id_rs_sel = rs; bus.id_rs_used = rsu; bus.id_rt_sel = rt;
    bus.id_rt_used = rtu; bus.id_rdata1 = d1; bus.id_rdata2 = 16'h5678; bus.id_imm = imm;
    bus.id_dst_sel = dst; bus.id_dst_we = 1; bus.id_is_load = 0; bus.id_ctl = ctl;
  endtask

  initial begin
    checks = 0; errors = 0; m_init = 0;
    rst = 1;
    set_idle();
    @(negedge clk);
    step(); step();

    // Reset state
    rst = 0;
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_dst_we",   32'(bus.ex_dst_we), 32'd0);
    chk("rst_cnt",      32'(bus.bubble_cnt), 32'd0);
    chk("rst_stall",    32'(bus.id_stall), 32'd0);

    // Independent registers: no stall, operand arrives next cycle
    set_instr(3'd0, 0, 3'd0, 0, 16'h0000, 16'h0001, 3'd1, 8'h11); step();
    set_instr(3'd2, 1, 3'd3, 1, 16'h1234, 16'h0002, 3'd4, 8'h22);
    #1 chk("indep_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("indep_ex_a", 32'(bus.ex_a), 32'h1234);
    chk("indep_valid", 32'(bus.ex_valid), 32'd1);

    // Back-to-back RAW on r3: stalls while writer sits in EX then MEM
    set_instr(3'd0, 0, 3'd0, 0, 16'h0000, 16'h0003, 3'd3, 8'h33); step();
    set_instr(3'd3, 1, 3'd0, 0, 16'hBEEF, 16'h0004, 3'd5, 8'h44);
    #1 chk("raw_stall_ex", 32'(bus.id_stall), 32'd1);
    step();
    bus.mem_dst_sel = 3'd3; bus.mem_dst_we = 1;
    #1 chk("raw_stall_mem", 32'(bus.id_stall), 32'd1);
    step();
    chk("raw_bubble", 32'(bus.ex_valid), 32'd0);
    bus.mem_dst_we = 0;
    #1 chk("raw_release", 32'(bus.id_stall), 32'd0);
    step();
    chk("raw_loaded", 32'(bus.ex_valid), 32'd1);
    chk("raw_ex_a",   32'(bus.ex_a), 32'hBEEF);
    chk("raw_cnt",    32'(bus.bubble_cnt), 32'd2);

    // Unused source matching EX dst is not a hazard
    set_instr(3'd0, 0, 3'd0, 0, 16'h0000, 16'h0005, 3'd3, 8'h55); step();
    set_instr(3'd0, 1, 3'd3, 0, 16'h0000, 16'h0006, 3'd6, 8'h66);
    #1 chk("unused_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("unused_imm", 32'(bus.ex_imm), 32'h0006);

    // Downstream hold with a pending hazard freezes EX and the counter
    set_instr(3'd6, 1, 3'd0, 0, 16'h7777, 16'h0007, 3'd7, 8'h77);
    bus.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", 32'(bus.id_stall), 32'd1);
      step();
      chk("hold_imm", 32'(bus.ex_imm), 32'h0006);
      chk("hold_cnt", 32'(bus.bubble_cnt), 32'd2);
    end
    bus.ex_stall = 0;
    step();
    chk("hold_bubble_cnt", 32'(bus.bubble_cnt), 32'd3);
    step();
    chk("hold_loaded_imm", 32'(bus.ex_imm), 32'h0007);

    // Flush beats ex_stall and hazard; counter untouched
    set_instr(3'd7, 1, 3'd0, 0, 16'h9999, 16'h0008, 3'd1, 8'h88);
    bus.ex_stall = 1; bus.flush = 1;
    #1 chk("flush_stall", 32'(bus.id_stall), 32'd0);
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_ex_a",  32'(bus.ex_a), 32'd0);
    chk("flush_cnt",   32'(bus.bubble_cnt), 32'd3);
    bus.ex_stall = 0; bus.flush = 0;

    // Two more bubbles: wide counter 5, 2-bit counter pinned at 3
    set_instr(3'd1, 1, 3'd1, 1, 16'h0101, 16'h0009, 3'd2, 8'h99);
    bus.mem_dst_sel = 3'd1; bus.mem_dst_we = 1;
    step(); step();
    chk("sat_cnt_wide",  32'(bus.bubble_cnt), 32'd5);
    chk("sat_cnt_small", 32'(bus2.bubble_cnt), 32'd3);

    // Reset during a stall leaves nothing pending
    rst = 1; step();
    rst = 0; set_idle();
    #1 chk("rst_mid_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_mid_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_mid_cnt",   32'(bus.bubble_cnt), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.ex_stall     = ($urandom_range(0, 4) == 0);
      bus.id_valid     = ($urandom_range(0, 3) != 0);
      bus.id_rs_sel    = 3'($urandom_range(0, 7));
      bus.id_rt_sel    = 3'($urandom_range(0, 7));
      bus.id_rs_used   = 1'($urandom);
      bus.id_rt_used   = 1'($urandom);
      bus.id_rdata1    = 16'($urandom);
      bus.id_rdata2    = 16'($urandom);
      bus.id_imm       = 16'($urandom);
      bus.id_dst_sel   = 3'($urandom_range(0, 7));
      bus.id_dst_we    = 1'($urandom);
      bus.id_is_load   = 1'($urandom);
      bus.id_ctl       = 8'($urandom);
      bus.mem_dst_sel  = 3'($urandom_range(0, 7));
      bus.mem_dst_we   = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0;
    set_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
